intpol2_d4_seq: RTL and testbench

INTPOL2_D4_SEQ -- requirements
Module: intpol2_D4_seq

---
 rtl/intpol2_d4_pkg.sv | 32 +++
 rtl/intpol2_d4_seq.sv | 91 +++++++++
 tb/tb_intpol2_d4_seq.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/intpol2_d4_pkg.sv
// Shared types for the 4-phase quadratic interpolator: sequencer states and
// the squared-term generator step codes used by the datapath.
package intpol2_D4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [1:0] SEL_ZERO = 2'b00;
  localparam logic [1:0] SEL_X2   = 2'b01;
  localparam logic [1:0] SEL_4X2  = 2'b10;
  localparam logic [1:0] SEL_SUM  = 2'b11;

  localparam logic [1:0] PHASE_LAST = 2'd3;

  // Each phase drives exactly one generator step; the codes are ordered so
  // phase n selects step n.
  function automatic logic [1:0] sel_for_phase(input logic [1:0] ph);
    logic [1:0] s;
    s = SEL_ZERO;
    case (ph)
      2'd0:    s = SEL_ZERO;
      2'd1:    s = SEL_X2;
      2'd2:    s = SEL_4X2;
      default: s = SEL_SUM;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/intpol2_d4_seq.sv
// Sequencer for 4x quadratic interpolation: one sample in, 4 outputs (STEP+HOLD each, 8 cycles/sample).
// Backpressure: out_ready=0 freezes HOLD with all outputs stable; in_ready only rises in IDLE or the last handshake.
module intpol2_d4_seq #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 coef_load,
  output logic                 en_xi2,
  output logic [1:0]           sel_xi2,
  output logic [1:0]           phase,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [CNT_WIDTH-1:0] sample_cnt
);
  import intpol2_D4_pkg::*;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t     state, state_nxt;
  logic [1:0] phase_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      phase      <= 2'd0;
      sample_cnt <= '0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
      if (clear)
        sample_cnt <= '0;
      else if (coef_load)
        sample_cnt <= sample_cnt + CNT_ONE;
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    in_ready  = 1'b0;
    en_xi2    = 1'b0;
    sel_xi2   = SEL_ZERO;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = ST_STEP;
          phase_nxt = 2'd0;
        end
      end
      ST_STEP: begin
        en_xi2    = 1'b1;
        sel_xi2   = sel_for_phase(phase);
        state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        out_last  = (phase == PHASE_LAST);
        if (out_ready) begin
          if (phase != PHASE_LAST) begin
            state_nxt = ST_STEP;
            phase_nxt = phase + 2'd1;
          end else begin
            // Last output handshake doubles as the next sample's acceptance slot.
            in_ready  = 1'b1;
            phase_nxt = 2'd0;
            state_nxt = in_valid ? ST_STEP : ST_IDLE;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        phase_nxt = 2'd0;
      end
    endcase
    if (clear) begin
      state_nxt = ST_IDLE;
      phase_nxt = 2'd0;
    end
  end

  assign coef_load = in_valid & in_ready & ~clear;

endmodule

// File: tb/tb_intpol2_d4_seq.sv
// Directed bench for intpol2_d4_seq: table-driven single-sample sequence plus
// hand-written reset, back-to-back, backpressure, clear and counter-wrap cases.
module tb_intpol2_d4_seq;

  logic        clk = 1'b0;
  logic        rstn;
  logic        clear;
  logic        in_valid;
  logic        out_ready;
  logic        in_ready, coef_load, en_xi2, out_valid, out_last;
  logic [1:0]  sel_xi2, phase;
  logic [15:0] sample_cnt;

  logic        in_ready4, coef_load4, en_xi24, out_valid4, out_last4;
  logic [1:0]  sel_xi24, phase4;
  logic [3:0]  sample_cnt4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  intpol2_d4_seq #(.CNT_WIDTH(16)) u_dut (
    .clk(clk), .rstn(rstn), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready), .coef_load(coef_load), .en_xi2(en_xi2),
    .sel_xi2(sel_xi2), .phase(phase), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .sample_cnt(sample_cnt)
  );

  intpol2_d4_seq #(.CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rstn(rstn), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready4), .coef_load(coef_load4), .en_xi2(en_xi24),
    .sel_xi2(sel_xi24), .phase(phase4), .out_valid(out_valid4),
    .out_ready(out_ready), .out_last(out_last4), .sample_cnt(sample_cnt4)
  );

  typedef struct {
    logic       iv;
    logic       ordy;
    logic       clr;
    logic [8:0] exp;
  } vec_t;

  // Observation word: {in_ready, coef_load, en_xi2, sel_xi2, phase, out_valid, out_last}
  function automatic logic [8:0] e(input logic ir, input logic cl, input logic en,
                                   input logic [1:0] sel, input logic [1:0] ph,
                                   input logic ov, input logic ls);
    return {ir, cl, en, sel, ph, ov, ls};
  endfunction

  function automatic logic [8:0] obs();
    return {in_ready, coef_load, en_xi2, sel_xi2, phase, out_valid, out_last};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // All tasks start and end at posedge+1.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    next();
    rstn = 1'b1;
  endtask

  vec_t tbl[10];

  initial begin
    rstn = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #2;
    chk("por_obs", {23'd0, obs()}, {23'd0, e(1,0,0,2'b00,2'd0,0,0)});
    chk("por_cnt", {16'd0, sample_cnt}, 32'd0);
    next();
    rstn = 1'b1;

    // Single sample, out_ready held high.
    tbl[0] = '{1'b1, 1'b1, 1'b0, e(1,1,0,2'b00,2'd0,0,0)};
    tbl[1] = '{1'b0, 1'b1, 1'b0, e(0,0,1,2'b00,2'd0,0,0)};
    tbl[2] = '{1'b0, 1'b1, 1'b0, e(0,0,0,2'b00,2'd0,1,0)};
    tbl[3] = '{1'b0, 1'b1, 1'b0, e(0,0,1,2'b01,2'd1,0,0)};
    tbl[4] = '{1'b0, 1'b1, 1'b0, e(0,0,0,2'b00,2'd1,1,0)};
    tbl[5] = '{1'b0, 1'b1, 1'b0, e(0,0,1,2'b10,2'd2,0,0)};
    tbl[6] = '{1'b0, 1'b1, 1'b0, e(0,0,0,2'b00,2'd2,1,0)};
    tbl[7] = '{1'b0, 1'b1, 1'b0, e(0,0,1,2'b11,2'd3,0,0)};
    tbl[8] = '{1'b0, 1'b1, 1'b0, e(1,0,0,2'b00,2'd3,1,1)};
    tbl[9] = '{1'b0, 1'b1, 1'b0, e(1,0,0,2'b00,2'd0,0,0)};
    for (int i = 0; i < 10; i++) begin
      in_valid = tbl[i].iv; out_ready = tbl[i].ordy; clear = tbl[i].clr;
      @(negedge clk);
      chk($sformatf("single[%0d]", i), {23'd0, obs()}, {23'd0, tbl[i].exp});
      next();
    end
    chk("single_cnt", {16'd0, sample_cnt}, 32'd1);

    // Back-to-back: acceptances at 0, 8, 16 with no idle gap.
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      chk($sformatf("b2b_accept[%0d]", c), {31'd0, coef_load}, {31'd0, (c % 8) == 0});
      if (c != 0)
        chk($sformatf("b2b_busy[%0d]", c), {31'd0, en_xi2 | out_valid}, 32'd1);
      next();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_cnt", {16'd0, sample_cnt}, 32'd3);
    for (int c = 0; c < 8; c++) next();

    // Backpressure in phase-1 HOLD.
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    next();
    in_valid = 1'b0;
    for (int c = 1; c < 4; c++) next();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp_hold[%0d]", c), {23'd0, obs()}, {23'd0, e(0,0,0,2'b00,2'd1,1,0)});
      next();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {23'd0, obs()}, {23'd0, e(0,0,0,2'b00,2'd1,1,0)});
    next();
    @(negedge clk);
    chk("bp_step2", {23'd0, obs()}, {23'd0, e(0,0,1,2'b10,2'd2,0,0)});
    next();

    // Clear in phase-2 HOLD with a coincident in_valid.
    do_reset();
    in_valid = 1'b1;
    next();
    in_valid = 1'b0;
    for (int c = 1; c < 6; c++) next();
    clear = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("clr_hold_ov", {31'd0, out_valid}, 32'd1);
    chk("clr_coef", {31'd0, coef_load}, 32'd0);
    next();
    clear = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("clr_after", {23'd0, obs()}, {23'd0, e(1,0,0,2'b00,2'd0,0,0)});
    chk("clr_cnt", {16'd0, sample_cnt}, 32'd0);
    next();

    // Asynchronous reset mid-group.
    in_valid = 1'b1;
    next();
    in_valid = 1'b0;
    for (int c = 1; c < 3; c++) next();
    #2 rstn = 1'b0;
    #1;
    chk("arst_obs", {23'd0, obs()}, {23'd0, e(1,0,0,2'b00,2'd0,0,0)});
    chk("arst_cnt", {16'd0, sample_cnt}, 32'd0);
    next();
    rstn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("arst_quiet[%0d]", c), {31'd0, en_xi2 | out_valid}, 32'd0);
      next();
    end

    // Counter wrap: 17 samples back-to-back.
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 129; c++) next();
    in_valid = 1'b0;
    @(negedge clk);
    chk("wrap_cnt4", {28'd0, sample_cnt4}, 32'd1);
    chk("wrap_cnt16", {16'd0, sample_cnt}, 32'd17);
    for (int c = 0; c < 8; c++) next();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
